// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round controller and its datapath:
// datapath step codes, round/step-length constants and the helpers that map
// a step to the start and terminal values of the step counter.
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ARK      = 4'd1,
        ST_SB       = 4'd2,
        ST_SR       = 4'd3,
        ST_MC       = 4'd4,
        ST_I_ARK    = 4'd5,
        ST_I_SB     = 4'd6,
        ST_I_SR     = 4'd7,
        ST_I_MC     = 4'd8,
        ST_DONE     = 4'd9,
        ST_FINISH   = 4'd10,
        ST_KEY_WAIT = 4'd11
    } step_e;

    localparam int NR        = 14;
    localparam int SB_CYCLES = 16;
    localparam int MC_CYCLES = 4;
    localparam int ARK_CNT   = 6;
    localparam int CNT_W     = 5;

    typedef logic signed [CNT_W-1:0] cnt_t;

    // Value the step counter takes on entry to a step.
    function automatic cnt_t step_cnt_init(input step_e s);
        if (s == ST_ARK || s == ST_I_ARK) begin
            return cnt_t'(ARK_CNT);
        end
        return '0;
    endfunction

    // Last count of a multi-cycle step; meaningless for one-cycle steps.
    function automatic cnt_t step_cnt_term(input step_e s);
        case (s)
            ST_SB, ST_I_SB: return cnt_t'(SB_CYCLES - 1);
            ST_MC, ST_I_MC: return cnt_t'(MC_CYCLES - 1);
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Handshake and status bundle of the AES round controller.
//   start, mode, abort       : block request / direction / cancel
//   in_ready, out_valid,
//   out_ready                : block-level handshake
//   rk_req, rk_idx, rk_valid : round-key request channel
//   current_state, round,
//   cnt, mode_switch, inv_en : datapath step control
//   stall_cycles             : KEY_WAIT cycle count (AES_CTRL_PERF_CNT_EN only)
// master = controller side, slave = datapath / environment side.
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic       start;
    logic       mode;
    logic       abort;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       rk_req;
    logic [3:0] rk_idx;
    logic       rk_valid;
    logic [3:0] current_state;
    logic [3:0] round;
    cnt_t       cnt;
    logic       mode_switch;
    logic       inv_en;
`ifdef AES_CTRL_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    modport master (
        input  start, mode, abort, out_ready, rk_valid,
`ifdef AES_CTRL_PERF_CNT_EN
        output stall_cycles,
`endif
        output in_ready, out_valid, rk_req, rk_idx, current_state, round, cnt,
               mode_switch, inv_en
    );

    modport slave (
        output start, mode, abort, out_ready, rk_valid,
`ifdef AES_CTRL_PERF_CNT_EN
        input  stall_cycles,
`endif
        input  in_ready, out_valid, rk_req, rk_idx, current_state, round, cnt,
               mode_switch, inv_en
    );

endinterface

// File: rtl/aes_step_cnt.sv
// ---------------------------------------------------------------------------
// aes_step_cnt
// Step index counter of the AES round controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : take load_val on the next edge (step change)
//   load_val   : entry value of the step being entered
//   inc        : current step counts one per cycle
//   term       : terminal value of the current step
//   cnt        : current step index
//   last       : cnt has reached term
// Counting stops at term so a stalled step never wraps.
// ---------------------------------------------------------------------------
module aes_step_cnt
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  cnt_t load_val,
    input  logic inc,
    input  cnt_t term,
    output cnt_t cnt,
    output logic last
);

    cnt_t cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (inc && !last) begin
            cnt_q <= cnt_q + cnt_t'(1);
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == term);

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Sequencing controller of an iterative AES-256 datapath. Walks the encrypt
// or decrypt step sequence one block at a time, requests a round key before
// every AddRoundKey step and parks in KEY_WAIT until the key is valid.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset; discards any block in flight
//   bus   : aes_round_ctrl_if.master (handshake, key channel, step control)
// Optional feature macro: AES_CTRL_PERF_CNT_EN adds bus.stall_cycles, a
// saturating count of KEY_WAIT cycles in the current block.
// ---------------------------------------------------------------------------
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    aes_round_ctrl_if.master      bus
);

    step_e      state_q;
    step_e      state_d;
    logic [3:0] round_q;
    logic [3:0] round_d;
    logic       mode_q;
    logic       mode_d;
    logic       start_acc;

    logic       cnt_load;
    logic       cnt_inc;
    logic       cnt_last;
    cnt_t       cnt_val;
    cnt_t       cnt_term;
    cnt_t       cnt_cur;

    // Next step when an AddRoundKey is due: straight in if the key is
    // already there, otherwise wait for it.
    function automatic step_e key_step(input logic dec, input logic key_ok);
        if (!key_ok) begin
            return ST_KEY_WAIT;
        end
        return dec ? ST_I_ARK : ST_ARK;
    endfunction

    assign start_acc = (state_q == ST_IDLE) && bus.start && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        mode_d  = mode_q;

        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_d  = bus.mode;
                        round_d = bus.mode ? 4'(NR) : 4'd0;
                        state_d = key_step(bus.mode, bus.rk_valid);
                    end
                end
                ST_KEY_WAIT: begin
                    if (bus.rk_valid) begin
                        state_d = mode_q ? ST_I_ARK : ST_ARK;
                    end
                end
                // Encrypt path
                ST_ARK: begin
                    if (round_q == 4'(NR)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SB;
                        round_d = round_q + 4'd1;
                    end
                end
                ST_SB: begin
                    if (cnt_last) state_d = ST_SR;
                end
                ST_SR: begin
                    // The final round has no MixColumns.
                    state_d = (round_q == 4'(NR)) ? key_step(1'b0, bus.rk_valid) : ST_MC;
                end
                ST_MC: begin
                    if (cnt_last) state_d = key_step(1'b0, bus.rk_valid);
                end
                // Decrypt path
                ST_I_ARK: begin
                    if (round_q == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        // The initial key addition of round NR has no
                        // following InvMixColumns.
                        state_d = (round_q == 4'(NR)) ? ST_I_SR : ST_I_MC;
                        round_d = round_q - 4'd1;
                    end
                end
                ST_I_SR: begin
                    state_d = ST_I_SB;
                end
                ST_I_SB: begin
                    if (cnt_last) state_d = key_step(1'b1, bus.rk_valid);
                end
                ST_I_MC: begin
                    if (cnt_last) state_d = ST_I_SR;
                end
                ST_DONE: begin
                    state_d = bus.out_ready ? ST_IDLE : ST_FINISH;
                end
                ST_FINISH: begin
                    if (bus.out_ready) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // IDLE always shows round 0, whichever way it was reached.
        if (state_d == ST_IDLE) begin
            round_d = '0;
        end
    end

    // Every step change reloads the counter, so an abort or a new step
    // always starts from its entry value.
    assign cnt_load = (state_d != state_q);
    assign cnt_val  = step_cnt_init(state_d);
    assign cnt_inc  = (state_q == ST_SB) || (state_q == ST_I_SB) ||
                      (state_q == ST_MC) || (state_q == ST_I_MC);
    assign cnt_term = step_cnt_term(state_q);

    aes_step_cnt u_step_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .inc      (cnt_inc),
        .term     (cnt_term),
        .cnt      (cnt_cur),
        .last     (cnt_last)
    );

`ifdef AES_CTRL_PERF_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (state_q == ST_KEY_WAIT && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_q;
`endif

    assign bus.current_state = state_q;
    assign bus.round         = round_q;
    assign bus.rk_idx        = round_q;
    assign bus.cnt           = cnt_cur;
    assign bus.in_ready      = (state_q == ST_IDLE);
    assign bus.out_valid     = (state_q == ST_DONE) || (state_q == ST_FINISH);
    assign bus.rk_req        = (state_q == ST_KEY_WAIT) || (state_q == ST_ARK) ||
                               (state_q == ST_I_ARK);
    assign bus.mode_switch   = mode_q;
    assign bus.inv_en        = mode_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl. The reference model expands the
// encrypt/decrypt step lists from the AES round structure and walks them one
// entry per cycle, inserting KEY_WAIT when a key is late.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    aes_round_ctrl_if bus();

    aes_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [3:0] rnd;
        int         cnt;
    } step_t;

    typedef struct {
        bit dec;
        int lo_start;
        int lo_len;
        int rdy_delay;
        bit noise;
        int exp_done;
        int exp_stall;
    } vec_t;

    step_t seq[$];
    int    checks;
    int    errors;

    // Model state: phase 0 idle, 1 walking seq, 2 holding the result.
    int    m_ph;
    int    m_idx;
    bit    m_kw;
    bit    m_dec;
    int    m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int st, input int r, input int c);
        step_t e;
        e.st  = 4'(st);
        e.rnd = 4'(r);
        e.cnt = c;
        seq.push_back(e);
    endfunction

    task automatic build_seq(input bit dec);
        seq.delete();
        if (!dec) begin
            push(1, 0, 6);
            for (int r = 1; r <= 14; r++) begin
                for (int c = 0; c < 16; c++) push(2, r, c);
                push(3, r, 0);
                if (r < 14) for (int c = 0; c < 4; c++) push(4, r, c);
                push(1, r, 6);
            end
            push(9, 14, 0);
        end else begin
            push(5, 14, 6);
            for (int r = 13; r >= 0; r--) begin
                push(7, r, 0);
                for (int c = 0; c < 16; c++) push(6, r, c);
                push(5, r, 6);
                // round already counted down on leaving the key addition
                if (r > 0) for (int c = 0; c < 4; c++) push(8, r - 1, c);
            end
            push(9, 0, 0);
        end
    endtask

    function automatic bit is_ark(input logic [3:0] st);
        return (st == 4'd1) || (st == 4'd5);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_ph = 0; m_stall = 0; m_dec = 0;
            return;
        end
        if (m_ph == 1 && m_kw && m_stall < 65535) m_stall++;
        if (bus.abort) begin
            m_ph = 0;
            return;
        end
        case (m_ph)
            0: if (bus.start) begin
                m_dec = bus.mode;
                build_seq(bus.mode);
                m_idx = 0;
                m_kw = !bus.rk_valid;
                m_ph = 1;
                m_stall = 0;
            end
            1: begin
                if (m_kw) begin
                    if (bus.rk_valid) m_kw = 0;
                end else if (seq[m_idx].st == 4'd9) begin
                    m_ph = bus.out_ready ? 0 : 2;
                end else begin
                    m_idx++;
                    m_kw = is_ark(seq[m_idx].st) && !bus.rk_valid;
                end
            end
            default: if (bus.out_ready) m_ph = 0;
        endcase
    endtask

    task automatic check_cycle();
        logic [3:0] est;
        logic [3:0] ernd;
        int         ec;
        if (m_ph == 0) begin
            est = 4'd0; ernd = 4'd0; ec = 0;
        end else if (m_ph == 2) begin
            est = 4'd10; ernd = seq[m_idx].rnd; ec = 0;
        end else if (m_kw) begin
            est = 4'd11; ernd = seq[m_idx].rnd; ec = 0;
        end else begin
            est = seq[m_idx].st; ernd = seq[m_idx].rnd; ec = seq[m_idx].cnt;
        end
        chk("state", 32'(bus.current_state), 32'(est));
        chk("round", 32'(bus.round), 32'(ernd));
        chk("cnt", 32'(bus.cnt), 32'(ec));
        chk("rk_idx", 32'(bus.rk_idx), 32'(ernd));
        chk("rk_req", 32'(bus.rk_req), 32'(est == 4'd1 || est == 4'd5 || est == 4'd11));
        chk("in_ready", 32'(bus.in_ready), 32'(est == 4'd0));
        chk("out_valid", 32'(bus.out_valid), 32'(est == 4'd9 || est == 4'd10));
        if (m_ph != 0) begin
            chk("mode_switch", 32'(bus.mode_switch), 32'(m_dec));
            chk("inv_en", 32'(bus.inv_en), 32'(m_dec));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_cycle();
    endtask

    task automatic run_block(input vec_t v, input bit rnd);
        int done_k;
        bit ended;
        done_k = -1;
        ended = 0;
        bus.mode = v.dec;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if (rnd) begin
                bus.rk_valid  = ($urandom_range(0, 3) != 0);
                bus.out_ready = ($urandom_range(0, 2) == 0);
                if (k > 0) bus.abort = ($urandom_range(0, 399) == 0);
            end else begin
                bus.rk_valid  = !(k >= v.lo_start && k < v.lo_start + v.lo_len);
                bus.out_ready = (k >= v.exp_done + v.rdy_delay);
            end
            if (k > 0) begin
                if (v.noise || rnd) begin
                    bus.start = ($urandom_range(0, 1) == 1) && (m_ph != 0);
                    bus.mode  = 1'($urandom_range(0, 1));
                end else begin
                    bus.start = 1'b0;
                end
            end
            tick();
            if (done_k < 0 && bus.current_state == 4'd9) done_k = k;
            if (k > 0 && m_ph == 0) begin
                ended = 1;
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("block_end", 32'(ended), 32'd1);
        if (!rnd) begin
            chk("done_cycle", 32'(done_k), 32'(v.exp_done));
`ifdef AES_CTRL_PERF_CNT_EN
            chk("stall_table", 32'(bus.stall_cycles), 32'(v.exp_stall));
`endif
        end
`ifdef AES_CTRL_PERF_CNT_EN
        chk("stall_model", 32'(bus.stall_cycles), 32'(m_stall));
`endif
    endtask

    initial begin
        vec_t vecs[5];
        checks = 0;
        errors = 0;
        // dec, rk_valid low start/len, out_ready delay, noise, DONE cycle, stalls
        vecs[0] = '{1'b0,   0, 0,  0, 1'b0, 305, 0};
        vecs[1] = '{1'b1,   0, 0,  0, 1'b1, 305, 0};
        vecs[2] = '{1'b0, 110, 3,  0, 1'b0, 308, 3};
        vecs[3] = '{1'b1,   0, 2,  0, 1'b0, 307, 2};
        vecs[4] = '{1'b0,   0, 0, 10, 1'b1, 305, 0};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.mode = 1'b0; bus.abort = 1'b0;
        bus.out_ready = 1'b0; bus.rk_valid = 1'b0;
        m_ph = 0; m_idx = 0; m_kw = 0; m_dec = 0; m_stall = 0;

        #12;
        check_cycle();
        chk("rst_mode_switch", 32'(bus.mode_switch), 32'd0);
        chk("rst_inv_en", 32'(bus.inv_en), 32'd0);
`ifdef AES_CTRL_PERF_CNT_EN
        chk("rst_stall", 32'(bus.stall_cycles), 32'd0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_block(vecs[i], 1'b0);
            tick();
        end

        // Abort in the middle of the first SubBytes.
        bus.mode = 1'b0; bus.rk_valid = 1'b1; bus.out_ready = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        chk("pre_abort_state", 32'(bus.current_state), 32'd2);
        chk("pre_abort_cnt", 32'(bus.cnt), 32'd7);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_state", 32'(bus.current_state), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        run_block(vecs[0], 1'b0);
        tick();

        // Randomised key latency, consumer back-pressure and rare aborts.
        for (int i = 0; i < 4; i++) begin
            vec_t rv;
            rv = '{bit'(i % 2), 0, 0, 0, 1'b1, 0, 0};
            run_block(rv, 1'b1);
            tick();
        end

        // Asynchronous reset in the middle of a decrypt block.
        bus.mode = 1'b1; bus.rk_valid = 1'b1; bus.out_ready = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (50) tick();
        #2;
        rst_n = 1'b0;
        m_ph = 0; m_stall = 0; m_dec = 0;
        #1;
        check_cycle();
        chk("arst_mode_switch", 32'(bus.mode_switch), 32'd0);
`ifdef AES_CTRL_PERF_CNT_EN
        chk("arst_stall", 32'(bus.stall_cycles), 32'd0);
`endif
        repeat (3) tick();
        #2;
        rst_n = 1'b1;
        tick();
        run_block(vecs[2], 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
